// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared op and state encodings for the MEM stage
package mem_stage_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that holds at its maximum value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment unless already at all-ones, so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: memory strobes, load latency, WB output register
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        ex_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
);

    state_e            state_q,    state_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic [REG_W-1:0]  wb_rd_q,    wb_rd_d;
    logic [REG_W-1:0]  load_rd_q,  load_rd_d;

    logic accept;
    logic is_load;
    logic is_store;

    // Admission: only in IDLE and only when the WB slot is free or draining this edge,
    // which guarantees a load's result always has a slot waiting for it.
    always_comb begin
        ex_ready  = reset && (state_q == ST_IDLE) && (!wb_valid_q || wb_ready);
        accept    = ex_valid && ex_ready;
        is_load   = accept && (ex_op == OP_LOAD);
        is_store  = accept && (ex_op == OP_STORE);
        mem_r     = is_load;
        mem_w     = is_store;
        // Gate address/data with accept so idle X on ex_* never reaches the memory.
        mem_addr  = (is_load || is_store) ? ex_addr : '0;
        mem_wdata = is_store ? ex_wdata : '0;
    end

    // Next-state and WB register update: drain first, then a fill in the same edge wins.
    always_comb begin
        state_d    = state_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        load_rd_d  = load_rd_q;

        if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && (ex_op == OP_ALU)) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ex_alu;
                    wb_rd_d    = ex_rd;
                end else if (is_load) begin
                    state_d   = ST_LOAD_WAIT;
                    load_rd_d = ex_rd;
                end
            end
            ST_LOAD_WAIT: begin
                // Memory read data is valid exactly one cycle after mem_r.
                wb_valid_d = 1'b1;
                wb_data_d  = mem_rdata;
                wb_rd_d    = load_rd_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and WB registers; reset drops any pending load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            load_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            load_rd_q  <= load_rd_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;

    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mem_r),
        .count (load_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_store_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mem_w),
        .count (store_cnt)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 11;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid;
    logic              ex_ready;
    logic [1:0]        ex_op;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_wdata;
    logic [DATA_W-1:0] ex_alu;
    logic [REG_W-1:0]  ex_rd;
    logic              mem_r;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_rd;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  store_cnt;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem [0:2047];

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu(ex_alu), .ex_rd(ex_rd),
        .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    // Data memory model with a registered 1-cycle read.
    always @(posedge clk) begin
        if (mem_w) mem[mem_addr] <= mem_wdata;
        if (mem_r) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] alu,
                         input logic [REG_W-1:0] rd);
        ex_valid = v;
        ex_op    = op;
        ex_addr  = a;
        ex_wdata = wd;
        ex_alu   = alu;
        ex_rd    = rd;
    endtask

    initial begin
        mem_rdata = '0;
        reset     = 1'b0;
        wb_ready  = 1'b1;
        drive(1'b1, 2'b10, 11'd5, 32'h1234, 32'h1, 5'd1);

        // 1. reset held with a valid op offered
        for (int i = 0; i < 3; i++) begin
            #2;
            check("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
            check("rst_mem_r", {31'd0, mem_r}, 32'd0);
            ex_op = 2'b11;
            #1;
            check("rst_mem_w", {31'd0, mem_w}, 32'd0);
            ex_op = 2'b10;
            tick();
            check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
            check("rst_load_cnt", {29'd0, load_cnt}, 32'd0);
            check("rst_store_cnt", {29'd0, store_cnt}, 32'd0);
        end
        reset = 1'b1;
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        tick();

        // 2. back-to-back ALU stream
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b01, '0, '0, 32'(i), 5'(i));
            #2;
            check("alu_ex_ready", {31'd0, ex_ready}, 32'd1);
            tick();
            check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("alu_wb_data", wb_data, 32'(i));
            check("alu_wb_rd", {27'd0, wb_rd}, 32'(i));
        end
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        tick();
        check("alu_drained", {31'd0, wb_valid}, 32'd0);

        // 3. store then load of the same word
        drive(1'b1, 2'b11, 11'd5, 32'hDEADBEEF, '0, '0);
        #2;
        check("st_mem_w", {31'd0, mem_w}, 32'd1);
        check("st_mem_r", {31'd0, mem_r}, 32'd0);
        check("st_mem_addr", {21'd0, mem_addr}, 32'd5);
        check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        check("st_store_cnt", {29'd0, store_cnt}, 32'd1);
        check("st_no_wb", {31'd0, wb_valid}, 32'd0);
        drive(1'b1, 2'b10, 11'd5, '0, '0, 5'd7);
        #2;
        check("ld_mem_r", {31'd0, mem_r}, 32'd1);
        check("ld_mem_w", {31'd0, mem_w}, 32'd0);
        check("ld_mem_addr", {21'd0, mem_addr}, 32'd5);
        tick();
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        #2;
        check("ld_wait_ready", {31'd0, ex_ready}, 32'd0);
        check("ld_wait_wb_valid", {31'd0, wb_valid}, 32'd0);
        tick();
        check("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("ld_wb_data", wb_data, 32'hDEADBEEF);
        check("ld_wb_rd", {27'd0, wb_rd}, 32'd7);
        check("ld_load_cnt", {29'd0, load_cnt}, 32'd1);
        tick();
        check("ld_drained", {31'd0, wb_valid}, 32'd0);

        // 4. backpressure: WB held, then drain and accept a load on the same edge
        wb_ready = 1'b0;
        drive(1'b1, 2'b01, '0, '0, 32'h55, 5'd3);
        tick();
        check("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("bp_wb_data", wb_data, 32'h55);
        drive(1'b1, 2'b10, 11'd5, '0, '0, 5'd9);
        #2;
        check("bp_ex_ready", {31'd0, ex_ready}, 32'd0);
        check("bp_mem_r", {31'd0, mem_r}, 32'd0);
        tick();
        check("bp_hold_valid", {31'd0, wb_valid}, 32'd1);
        check("bp_hold_data", wb_data, 32'h55);
        check("bp_hold_rd", {27'd0, wb_rd}, 32'd3);
        wb_ready = 1'b1;
        #2;
        check("bp_release_ready", {31'd0, ex_ready}, 32'd1);
        check("bp_release_mem_r", {31'd0, mem_r}, 32'd1);
        tick();
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        check("bp_drained", {31'd0, wb_valid}, 32'd0);
        tick();
        check("bp_ld_valid", {31'd0, wb_valid}, 32'd1);
        check("bp_ld_data", wb_data, 32'hDEADBEEF);
        check("bp_ld_rd", {27'd0, wb_rd}, 32'd9);
        check("bp_load_cnt", {29'd0, load_cnt}, 32'd2);
        tick();

        // 5. reset asserted while a load is pending
        drive(1'b1, 2'b10, 11'd5, '0, '0, 5'd4);
        tick();
        check("rl_load_cnt_pre", {29'd0, load_cnt}, 32'd3);
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        reset = 1'b0;
        #2;
        check("rl_ex_ready", {31'd0, ex_ready}, 32'd0);
        tick();
        check("rl_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rl_load_cnt", {29'd0, load_cnt}, 32'd0);
        check("rl_store_cnt", {29'd0, store_cnt}, 32'd0);
        reset = 1'b1;
        tick();
        check("rl_after_valid", {31'd0, wb_valid}, 32'd0);
        check("rl_after_ready", {31'd0, ex_ready}, 32'd1);

        // 6. store counter saturates at 7
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 2'b11, 11'(100 + i), 32'(i), '0, '0);
            tick();
            check("sat_store_cnt", {29'd0, store_cnt}, (i > 7) ? 32'd7 : 32'(i));
        end
        drive(1'b0, 2'b00, '0, '0, '0, '0);
        tick();
        check("sat_hold", {29'd0, store_cnt}, 32'd7);
        check("sat_load_cnt", {29'd0, load_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
